// File: rtl/activity_trigger_gen.sv
// activity_trigger_gen: watches a valid/ready stream, groups completed frames
// and emits rate-limited single-cycle trigger pulses. Purely observational.
module activity_trigger_gen #(
  parameter int unsigned FRAMES_PER_PULSE = 4,
  parameter int unsigned HOLDOFF_CYCLES   = 33554432,
  parameter int unsigned FRAME_CNT_W      = $clog2(FRAMES_PER_PULSE + 1),
  parameter int unsigned HOLDOFF_W        = $clog2(HOLDOFF_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        in_valid,
  input  logic        in_ready,
  input  logic        in_last,
  output logic        trigger,
  output logic        busy,
  output logic [31:0] frame_count,
  output logic [15:0] coalesced_count
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HOLDOFF = 1'b1
  } state_t;

  localparam logic [FRAME_CNT_W-1:0] GRP_LAST  = FRAME_CNT_W'(FRAMES_PER_PULSE - 1);
  localparam logic [HOLDOFF_W-1:0]   HOLD_LOAD = HOLDOFF_W'(HOLDOFF_CYCLES - 1);

  state_t                 r_state;
  logic [HOLDOFF_W-1:0]   r_hold_cnt;
  logic                   r_pending;
  logic                   r_trigger;
  logic [FRAME_CNT_W-1:0] r_grp_cnt;
  logic [31:0]            r_frame_count;
  logic [15:0]            r_coal_count;

  logic                   w_frame_done;
  logic                   w_group_done;
  state_t                 w_state_nxt;
  logic [HOLDOFF_W-1:0]   w_hold_nxt;
  logic                   w_pend_nxt;
  logic                   w_trig_nxt;
  logic                   w_coal_inc;

  assign w_frame_done = enable & in_valid & in_ready & in_last;
  assign w_group_done = w_frame_done & (r_grp_cnt == GRP_LAST);

  // Next-state logic: trigger issue, holdoff countdown, pending/coalesce bookkeeping.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_pend_nxt  = r_pending;
    w_trig_nxt  = 1'b0;
    w_coal_inc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_group_done) begin
          w_trig_nxt  = 1'b1;
          w_state_nxt = ST_HOLDOFF;
          w_hold_nxt  = HOLD_LOAD;
        end
      end
      ST_HOLDOFF: begin
        if (r_hold_cnt != '0) begin
          w_hold_nxt = r_hold_cnt - HOLDOFF_W'(1);
          if (w_group_done) begin
            if (r_pending) w_coal_inc = 1'b1;
            else           w_pend_nxt = 1'b1;
          end
        end else if (r_pending || w_group_done) begin
          // Window expired with work queued: fire once and start a fresh window.
          w_trig_nxt = 1'b1;
          w_hold_nxt = HOLD_LOAD;
          w_pend_nxt = 1'b0;
          w_coal_inc = r_pending & w_group_done;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, holdoff counter, pending flag and registered trigger.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it only takes effect on a clock edge.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_pending  <= 1'b0;
      r_trigger  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_pending  <= w_pend_nxt;
      r_trigger  <= w_trig_nxt;
    end
  end

  // Frame bookkeeping: group counter, wrapping frame total, saturating coalesce count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grp_cnt     <= '0;
      r_frame_count <= '0;
      r_coal_count  <= '0;
    end else begin
      if (w_frame_done) begin
        r_frame_count <= r_frame_count + 32'd1;
        r_grp_cnt     <= w_group_done ? '0 : r_grp_cnt + FRAME_CNT_W'(1);
      end
      if (w_coal_inc && (r_coal_count != 16'hFFFF)) begin
        r_coal_count <= r_coal_count + 16'd1;
      end
    end
  end

  assign trigger         = r_trigger;
  assign busy            = (r_state == ST_HOLDOFF);
  assign frame_count     = r_frame_count;
  assign coalesced_count = r_coal_count;

endmodule

// File: tb/tb_activity_trigger_gen.sv
// Self-checking bench for activity_trigger_gen (FRAMES_PER_PULSE=2, HOLDOFF_CYCLES=8):
// a vector table, directed multi-cycle sequences, then random traffic against a
// time-based reference model.
module tb_activity_trigger_gen;

  localparam int FPP = 2;
  localparam int H   = 8;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic        trigger;
  logic        busy;
  logic [31:0] frame_count;
  logic [15:0] coalesced_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  activity_trigger_gen #(
    .FRAMES_PER_PULSE(FPP),
    .HOLDOFF_CYCLES  (H)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_last        (in_last),
    .trigger        (trigger),
    .busy           (busy),
    .frame_count    (frame_count),
    .coalesced_count(coalesced_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_in(input logic e, input logic v, input logic r, input logic l);
    enable   = e;
    in_valid = v;
    in_ready = r;
    in_last  = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    cyc = 0;
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Directed sequence: frame_done in the cycles set in fd_mask, optional reset in
  // cycle rst_at; trigger/busy compared every cycle, counters at the end.
  task automatic run_seq(input string nm, input logic [63:0] fd_mask, input int rst_at,
                         input logic [63:0] trig_mask, input logic [63:0] busy_mask,
                         input int ncyc, input logic [31:0] fc_exp, input logic [15:0] cc_exp);
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      if (fd_mask[c]) set_in(1'b1, 1'b1, 1'b1, 1'b1);
      else            set_in(1'b0, 1'b0, 1'b0, 1'b0);
      rst = (c == rst_at);
      tick();
      check({nm, " trigger"}, 32'(trigger), 32'(trig_mask[c+1]));
      check({nm, " busy"},    32'(busy),    32'(busy_mask[c+1]));
    end
    rst = 1'b0;
    check({nm, " frame_count"},     frame_count,          fc_exp);
    check({nm, " coalesced_count"}, 32'(coalesced_count), 32'(cc_exp));
  endtask

  // Reference model: windows are tracked by the cycle of the last trigger; a
  // group is complete whenever the running frame total reaches a multiple of FPP.
  int          m_cyc;
  int          m_last;
  bit          m_pending;
  int unsigned m_frames;
  int          m_coal;
  bit          m_trig;
  bit          m_busy;

  task automatic model_step(input bit r, input bit fd);
    bit gd;
    bit fire;
    int k;
    if (r) begin
      m_pending = 0;
      m_frames  = 0;
      m_coal    = 0;
      m_cyc++;
      m_last    = m_cyc - 1000;
      m_trig    = 0;
      m_busy    = 0;
      return;
    end
    gd   = fd && (((m_frames + 1) % FPP) == 0);
    k    = m_cyc - m_last;
    fire = 0;
    if (k < 0 || k >= H) begin
      fire = gd;
    end else if (k == H - 1) begin
      fire = m_pending || gd;
      if (m_pending && gd && m_coal < 65535) m_coal++;
      m_pending = 0;
    end else if (gd) begin
      if (m_pending) begin
        if (m_coal < 65535) m_coal++;
      end else begin
        m_pending = 1;
      end
    end
    if (fd) m_frames++;
    m_cyc++;
    if (fire) m_last = m_cyc;
    k      = m_cyc - m_last;
    m_trig = fire;
    m_busy = (k >= 0 && k < H);
  endtask

  typedef struct packed {
    logic        rst;
    logic        en;
    logic        v;
    logic        r;
    logic        l;
    logic        trig;
    logic        busy;
    logic [31:0] fc;
    logic [15:0] cc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with live traffic, gating, back-pressure and enable hold.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 16'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 16'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 16'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 16'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd2, 16'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 16'd0};

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst;
      set_in(vecs[i].en, vecs[i].v, vecs[i].r, vecs[i].l);
      tick();
      check($sformatf("vec%0d trigger", i), 32'(trigger), 32'(vecs[i].trig));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d frame_count", i), frame_count, vecs[i].fc);
      check($sformatf("vec%0d coalesced", i), 32'(coalesced_count), 32'(vecs[i].cc));
    end

    // Basic group: frames at 10 and 15 -> trigger at 16, busy 16..23.
    run_seq("basic", rng(10, 10) | rng(15, 15), -1, rng(16, 16), rng(16, 23), 30, 32'd2, 16'd0);
    // Pending: groups at 10 and 13 -> triggers at 11 and 19, busy 11..26.
    run_seq("pending", rng(9, 10) | rng(12, 13), -1, rng(11, 11) | rng(19, 19), rng(11, 26),
            32, 32'd4, 16'd0);
    // Coalescing: groups at 10, 12, 14 -> one extra trigger at 19, one coalesced.
    run_seq("coalesce", rng(9, 14), -1, rng(11, 11) | rng(19, 19), rng(11, 26), 32, 32'd6, 16'd1);
    // Reset mid-holdoff with pending set: reset in cycle 14, nothing afterwards.
    run_seq("rst_mid", rng(9, 10) | rng(12, 13), 14, rng(11, 11), rng(11, 14), 32, 32'd0, 16'd0);

    // Random traffic against the reference model, density varied by phase.
    for (int i = 0; i < 1500; i++) begin
      bit r;
      bit fd;
      int p;
      p = (i / 250) % 3;
      r = (i == 0) || ($urandom_range(0, 299) == 0);
      case (p)
        0:       set_in(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0),
                        1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        1:       set_in(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 4) != 0));
        default: set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
      endcase
      rst = r;
      fd  = enable & in_valid & in_ready & in_last;
      model_step(r, fd);
      tick();
      check("rand trigger", 32'(trigger), 32'(m_trig));
      check("rand busy", 32'(busy), 32'(m_busy));
      check("rand frame_count", frame_count, m_frames);
      check("rand coalesced", 32'(coalesced_count), 32'(m_coal));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/activity_trigger_gen.md
# activity_trigger_gen

Monitors a valid/ready streaming interface (e.g. the accelerator's output frame stream) and converts completed frames into rate-limited single-cycle `trigger` pulses for the downstream `activity_led_blink` stage. One pulse is produced per `FRAMES_PER_PULSE` completed frames. A holdoff window enforces a minimum pulse spacing, and one group arriving during holdoff is held pending; any further groups in that window are coalesced and counted. The block is purely observational: it never drives `in_ready` or back-pressures the stream.

## Interface
- `FRAMES_PER_PULSE`, 4: completed frames per trigger group; ≥1.
- `HOLDOFF_CYCLES`, 33554432: minimum cycles between trigger rising edges; ≥1. Set ≥ downstream LED blink duration.
- `FRAME_CNT_W`, derived `$clog2(FRAMES_PER_PULSE+1)`: internal group counter width.
- `HOLDOFF_W`, derived `$clog2(HOLDOFF_CYCLES+1)`: holdoff counter width.
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `enable`  input  1  counts frames when high.
- `in_valid`  input  1  monitored stream valid.
- `in_ready`  input  1  monitored stream ready.
- `in_last`  input  1  monitored stream end-of-frame marker.
- `trigger`  output  1  registered single-cycle pulse; connect to LED stage `trigger`.
- `busy`  output  1  high while in HOLDOFF.
- `frame_count`  output  32  total completed frames; wraps modulo 2^32.
- `coalesced_count`  output  16  groups dropped because pending was already set; saturates at 0xFFFF.

## Operation
- `frame_done = enable & in_valid & in_ready & in_last`, evaluated combinationally each cycle.
- On each `frame_done`:
  - `frame_count` increments.
  - The group counter increments. If it equals `FRAMES_PER_PULSE-1`, it wraps to 0 and `group_done` is asserted that cycle.
- State machine: IDLE, HOLDOFF.
  - **IDLE, `group_done`:** next cycle `trigger`=1, state=HOLDOFF, `hold_cnt` loaded with `HOLDOFF_CYCLES-1`.
  - **HOLDOFF, `hold_cnt`≠0:** `hold_cnt` decrements. On `group_done`: if `pending`=0, set `pending`; else increment `coalesced_count` (saturating).
  - **HOLDOFF, `hold_cnt`=0:**
    - If `pending` or `group_done`: next cycle `trigger`=1, `hold_cnt` reloaded, `pending` cleared, state stays HOLDOFF.
    - Otherwise: state goes to IDLE.
    - If `pending` and `group_done` are both set, one trigger fires and `coalesced_count` increments.
- `enable`=0 only suppresses `frame_done`. Holdoff and `pending` service continue, and the group counter holds its value.
- `busy` = (state==HOLDOFF).

## Timing
- **Reset** (`rst`=1 at an edge): `trigger`=0, `busy`=0, `frame_count`=0, `coalesced_count`=0, group counter=0, `pending`=0, state=IDLE. Values are visible the cycle after the edge.
- **Reset mid-holdoff:** the pending group is discarded and no trigger is emitted.
- **Latency:** a `group_done` in IDLE at cycle t gives `trigger` high in cycle t+1 only, with `busy` high from t+1.
- **Pulse spacing:** trigger rising edges are at least `HOLDOFF_CYCLES` cycles apart. A pending trigger fires exactly `HOLDOFF_CYCLES` cycles after the previous one.
- **Counters:** `frame_count` and `coalesced_count` are registered and update the cycle after the event.
- **`HOLDOFF_CYCLES`=1:** `hold_cnt` loads 0, so back-to-back groups produce a trigger every cycle.
- **`FRAMES_PER_PULSE`=1:** every `frame_done` is a `group_done`.
- **Ignored beats:** beats with `in_last`=0, or with valid/ready not both high, have no effect.

## Test plan
All scenarios use `FRAMES_PER_PULSE`=2, `HOLDOFF_CYCLES`=8.

1. **Reset values:** assert `rst` for 2 cycles with stream traffic active. Required: all outputs 0 during reset and 0 on the first cycle after it.
2. **Basic group:** two `frame_done` beats at cycles 10 and 15. Required: `trigger` high only at cycle 16; `busy` high cycles 16–23, low at 24; `frame_count`=2.
3. **Pending during holdoff:** groups complete at cycles 10 (trigger at 11) and 13. Required: second trigger at cycle 19 and none between; `busy` stays high through cycle 26.
4. **Coalescing:** three groups complete within one holdoff window. Required: exactly one extra trigger at window end; `coalesced_count`=1.
5. **Gating and back-pressure:**
   - `in_last` beats with `in_ready`=0 produce no count and no trigger.
   - `enable`=0 for one frame holds the group count; the trigger occurs only after two enabled frames.
6. **Reset mid-holdoff:** with `pending`=1, assert `rst` at cycle 14. Required: no trigger after reset; `busy`=0; counters 0.
